// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage and the data memory.
// master: req, we, addr, wdata, be out; rdata, ack in.
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: EXE bundle in, registered MEM->WB bundle out.
// Ports: clk/rst, exe_* bundle, stall, mem_* bundle, dmem bus (master).
module mem_access_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_valid,
  input  logic [31:0] exe_result,
  input  logic [31:0] exe_rs2,
  input  logic [4:0]  exe_rd,
  input  logic        exe_Wmem,
  input  logic        exe_Rmem,
  input  logic        exe_Wreg,
  input  logic [2:0]  exe_func3,
  output logic        stall,
  output logic        mem_valid,
  output logic [4:0]  mem_rd,
  output logic [31:0] mem_result,
  output logic        mem_Wreg,
  output logic        mem_Rmem,
  output logic        mem_fault,
  mem_access_stage_if.master dmem
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state;

  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_be;
  logic        a_we;
  logic [4:0]  a_rd;
  logic [2:0]  a_f3;
  logic        a_wreg;

  logic        is_mem;
  logic        ld_ok;
  logic        st_ok;
  logic        align_ok;
  logic        legal;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  logic        busy;

  assign busy  = (state == BUSY);
  assign stall = busy;

  // Bus is quiet outside BUSY.
  assign dmem.req   = busy;
  assign dmem.we    = busy & a_we;
  assign dmem.addr  = busy ? {a_addr[31:2], 2'b00} : 32'h0;
  assign dmem.wdata = busy ? a_wdata : 32'h0;
  assign dmem.be    = busy ? a_be : 4'h0;

  assign is_mem = exe_Wmem | exe_Rmem;

  always_comb begin
    ld_ok    = 1'b0;
    st_ok    = 1'b0;
    align_ok = 1'b1;
    case (exe_func3)
      3'b000: begin ld_ok = 1'b1; st_ok = 1'b1; end
      3'b001: begin ld_ok = 1'b1; st_ok = 1'b1; end
      3'b010: begin ld_ok = 1'b1; st_ok = 1'b1; end
      3'b100: ld_ok = 1'b1;
      3'b101: ld_ok = 1'b1;
      default: begin ld_ok = 1'b0; st_ok = 1'b0; end
    endcase
    case (exe_func3[1:0])
      2'b01:   align_ok = ~exe_result[0];
      2'b10:   align_ok = (exe_result[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    legal = (exe_Wmem ^ exe_Rmem)
          & (exe_Rmem ? ld_ok : st_ok)
          & align_ok;
  end

  // Store lanes: replicate data so the enabled lanes carry it.
  always_comb begin
    st_wdata = exe_rs2;
    st_be    = 4'b1111;
    case (exe_func3[1:0])
      2'b00: begin
        st_wdata = {4{exe_rs2[7:0]}};
        st_be    = 4'b0001 << exe_result[1:0];
      end
      2'b01: begin
        st_wdata = {2{exe_rs2[15:0]}};
        st_be    = exe_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = exe_rs2;
        st_be    = 4'b1111;
      end
    endcase
  end

  // Load lane select and extension.
  always_comb begin
    ld_byte = dmem.rdata[7:0];
    case (a_addr[1:0])
      2'b00: ld_byte = dmem.rdata[7:0];
      2'b01: ld_byte = dmem.rdata[15:8];
      2'b10: ld_byte = dmem.rdata[23:16];
      2'b11: ld_byte = dmem.rdata[31:24];
      default: ld_byte = dmem.rdata[7:0];
    endcase
    ld_half = a_addr[1] ? dmem.rdata[31:16]
                        : dmem.rdata[15:0];
    ld_data = dmem.rdata;
    case (a_f3)
      3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100: ld_data = {24'h0, ld_byte};
      3'b001: ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101: ld_data = {16'h0, ld_half};
      default: ld_data = dmem.rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_valid  <= 1'b0;
      mem_rd     <= 5'h0;
      mem_result <= 32'h0;
      mem_Wreg   <= 1'b0;
      mem_Rmem   <= 1'b0;
      mem_fault  <= 1'b0;
      a_addr     <= 32'h0;
      a_wdata    <= 32'h0;
      a_be       <= 4'h0;
      a_we       <= 1'b0;
      a_rd       <= 5'h0;
      a_f3       <= 3'h0;
      a_wreg     <= 1'b0;
    end else begin
      // MEM bundle is a single-cycle pulse; idle is all zero.
      mem_valid  <= 1'b0;
      mem_rd     <= 5'h0;
      mem_result <= 32'h0;
      mem_Wreg   <= 1'b0;
      mem_Rmem   <= 1'b0;
      mem_fault  <= 1'b0;
      case (state)
        IDLE: begin
          if (exe_valid) begin
            if (!is_mem) begin
              mem_valid  <= 1'b1;
              mem_rd     <= exe_rd;
              mem_result <= exe_result;
              mem_Wreg   <= exe_Wreg;
            end else if (!legal) begin
              mem_valid  <= 1'b1;
              mem_fault  <= 1'b1;
              mem_rd     <= exe_rd;
              mem_result <= exe_result;
            end else begin
              a_addr  <= exe_result;
              a_wdata <= exe_Wmem ? st_wdata : 32'h0;
              a_be    <= exe_Wmem ? st_be : 4'b1111;
              a_we    <= exe_Wmem;
              a_rd    <= exe_rd;
              a_f3    <= exe_func3;
              a_wreg  <= exe_Wreg;
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dmem.ack) begin
            state     <= IDLE;
            mem_valid <= 1'b1;
            mem_rd    <= a_rd;
            if (a_we) begin
              mem_result <= a_addr;
            end else begin
              mem_result <= ld_data;
              mem_Rmem   <= 1'b1;
              mem_Wreg   <= a_wreg;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage.
// One task per scenario, inline checks, single summary line.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exe_valid = 1'b0;
  logic [31:0] exe_result = '0;
  logic [31:0] exe_rs2 = '0;
  logic [4:0]  exe_rd = '0;
  logic        exe_Wmem = 1'b0;
  logic        exe_Rmem = 1'b0;
  logic        exe_Wreg = 1'b0;
  logic [2:0]  exe_func3 = '0;
  logic        stall;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        mem_Wreg;
  logic        mem_Rmem;
  logic        mem_fault;

  int vectors = 0;
  int miscompares = 0;

  mem_access_stage_if dmem ();

  mem_access_stage dut (
    .clk        (clk),
    .rst        (rst),
    .exe_valid  (exe_valid),
    .exe_result (exe_result),
    .exe_rs2    (exe_rs2),
    .exe_rd     (exe_rd),
    .exe_Wmem   (exe_Wmem),
    .exe_Rmem   (exe_Rmem),
    .exe_Wreg   (exe_Wreg),
    .exe_func3  (exe_func3),
    .stall      (stall),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_result (mem_result),
    .mem_Wreg   (mem_Wreg),
    .mem_Rmem   (mem_Rmem),
    .mem_fault  (mem_fault),
    .dmem       (dmem.master)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic present(
    input logic [31:0] addr,
    input logic [31:0] rs2,
    input logic [4:0]  rd,
    input logic        w,
    input logic        r,
    input logic        wreg,
    input logic [2:0]  f3
  );
    exe_valid  = 1'b1;
    exe_result = addr;
    exe_rs2    = rs2;
    exe_rd     = rd;
    exe_Wmem   = w;
    exe_Rmem   = r;
    exe_Wreg   = wreg;
    exe_func3  = f3;
  endtask

  task automatic idle_in;
    exe_valid = 1'b0;
    exe_Wmem  = 1'b0;
    exe_Rmem  = 1'b0;
    exe_Wreg  = 1'b0;
  endtask

  task automatic test_reset;
    vectors++;
    if (mem_valid !== 1'b0 || stall !== 1'b0 || dmem.req !== 1'b0
        || mem_result !== 32'h0) begin
      $display("FAIL reset_state valid=%b stall=%b req=%b res=%h want 0",
               mem_valid, stall, dmem.req, mem_result);
      miscompares++;
    end
    present(32'h0000_0100, 32'h1, 5'd3, 1'b1, 1'b0, 1'b0, 3'b010);
    step;
    vectors++;
    if (stall !== 1'b1 || dmem.req !== 1'b1) begin
      $display("FAIL reset_busy stall=%b req=%b want 1/1",
               stall, dmem.req);
      miscompares++;
    end
    rst = 1'b1;
    step;
    step;
    idle_in;
    vectors++;
    if (stall !== 1'b0 || dmem.req !== 1'b0 || mem_valid !== 1'b0
        || mem_rd !== 5'd0 || mem_result !== 32'h0 || mem_fault !== 1'b0
        || mem_Wreg !== 1'b0 || mem_Rmem !== 1'b0) begin
      $display("FAIL reset_mid_busy stall=%b req=%b valid=%b res=%h want 0",
               stall, dmem.req, mem_valid, mem_result);
      miscompares++;
    end
    rst = 1'b0;
    dmem.ack = 1'b1;
    step;
    dmem.ack = 1'b0;
    vectors++;
    if (mem_valid !== 1'b0 || stall !== 1'b0) begin
      $display("FAIL late_ack valid=%b stall=%b want 0/0",
               mem_valid, stall);
      miscompares++;
    end
  endtask

  task automatic test_pass_through;
    present(32'h1234_5678, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 3'b000);
    vectors++;
    if (stall !== 1'b0) begin
      $display("FAIL pass_stall got=%b want 0", stall);
      miscompares++;
    end
    step;
    idle_in;
    vectors++;
    if (mem_valid !== 1'b1 || mem_result !== 32'h1234_5678
        || mem_rd !== 5'd5 || mem_Wreg !== 1'b1 || mem_Rmem !== 1'b0
        || mem_fault !== 1'b0 || stall !== 1'b0) begin
      $display("FAIL pass_out v=%b res=%h rd=%0d w=%b r=%b f=%b s=%b want 1/12345678/5/1/0/0/0",
               mem_valid, mem_result, mem_rd, mem_Wreg, mem_Rmem,
               mem_fault, stall);
      miscompares++;
    end
    step;
    vectors++;
    if (mem_valid !== 1'b0) begin
      $display("FAIL pass_pulse valid=%b want 0", mem_valid);
      miscompares++;
    end
  endtask

  task automatic test_store_byte;
    int stalls;
    stalls = 0;
    present(32'h0000_1003, 32'hAABB_CCDD, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000);
    step;
    idle_in;
    vectors++;
    if (dmem.addr !== 32'h0000_1000 || dmem.be !== 4'b1000
        || dmem.wdata !== 32'hDDDD_DDDD || dmem.we !== 1'b1
        || dmem.req !== 1'b1) begin
      $display("FAIL sb_bus addr=%h be=%b wdata=%h we=%b req=%b want 1000/1000/dddddddd/1/1",
               dmem.addr, dmem.be, dmem.wdata, dmem.we, dmem.req);
      miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      if (stall === 1'b1) stalls++;
      vectors++;
      if (mem_valid !== 1'b0) begin
        $display("FAIL sb_bubble cycle=%0d valid=%b want 0", i, mem_valid);
        miscompares++;
      end
      if (i == 2) dmem.ack = 1'b1;
      step;
    end
    dmem.ack = 1'b0;
    vectors++;
    if (stalls != 3) begin
      $display("FAIL sb_stall_cycles got=%0d want 3", stalls);
      miscompares++;
    end
    vectors++;
    if (mem_valid !== 1'b1 || mem_Wreg !== 1'b0 || mem_Rmem !== 1'b0
        || mem_result !== 32'h0000_1003 || stall !== 1'b0
        || dmem.req !== 1'b0) begin
      $display("FAIL sb_done v=%b w=%b r=%b res=%h s=%b req=%b want 1/0/0/00001003/0/0",
               mem_valid, mem_Wreg, mem_Rmem, mem_result, stall, dmem.req);
      miscompares++;
    end
  endtask

  task automatic test_load(
    input string       name,
    input logic [31:0] addr,
    input logic [31:0] rdata,
    input logic [2:0]  f3,
    input logic [31:0] exp
  );
    present(addr, 32'h0, 5'd9, 1'b0, 1'b1, 1'b1, f3);
    step;
    idle_in;
    vectors++;
    if (dmem.req !== 1'b1 || dmem.we !== 1'b0 || dmem.be !== 4'b1111
        || dmem.addr !== {addr[31:2], 2'b00}) begin
      $display("FAIL %s_bus req=%b we=%b be=%b addr=%h want 1/0/1111/%h",
               name, dmem.req, dmem.we, dmem.be, dmem.addr,
               {addr[31:2], 2'b00});
      miscompares++;
    end
    dmem.rdata = rdata;
    dmem.ack   = 1'b1;
    step;
    dmem.ack   = 1'b0;
    vectors++;
    if (mem_valid !== 1'b1 || mem_result !== exp || mem_Rmem !== 1'b1
        || mem_Wreg !== 1'b1 || mem_rd !== 5'd9) begin
      $display("FAIL %s_result v=%b res=%h r=%b w=%b rd=%0d want 1/%h/1/1/9",
               name, mem_valid, mem_result, mem_Rmem, mem_Wreg, mem_rd, exp);
      miscompares++;
    end
  endtask

  task automatic test_fault(
    input string       name,
    input logic [31:0] addr,
    input logic [2:0]  f3
  );
    present(addr, 32'h0, 5'd4, 1'b0, 1'b1, 1'b1, f3);
    step;
    idle_in;
    vectors++;
    if (dmem.req !== 1'b0 || stall !== 1'b0 || mem_fault !== 1'b1
        || mem_valid !== 1'b1 || mem_Wreg !== 1'b0
        || mem_result !== addr || mem_rd !== 5'd4) begin
      $display("FAIL %s req=%b s=%b f=%b v=%b w=%b res=%h rd=%0d want 0/0/1/1/0/%h/4",
               name, dmem.req, stall, mem_fault, mem_valid, mem_Wreg,
               mem_result, mem_rd, addr);
      miscompares++;
    end
    step;
    vectors++;
    if (mem_fault !== 1'b0 || mem_valid !== 1'b0) begin
      $display("FAIL %s_pulse f=%b v=%b want 0/0", name, mem_fault, mem_valid);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back;
    int pulses;
    pulses = 0;
    present(32'h0000_3000, 32'h0, 5'd7, 1'b0, 1'b1, 1'b1, 3'b010);
    step;
    present(32'h0000_3004, 32'hCAFE_F00D, 5'd8, 1'b1, 1'b0, 1'b0, 3'b010);
    dmem.rdata = 32'h1122_3344;
    dmem.ack   = 1'b1;
    step;
    dmem.ack   = 1'b0;
    if (mem_valid === 1'b1) pulses++;
    vectors++;
    if (mem_result !== 32'h1122_3344 || mem_rd !== 5'd7
        || stall !== 1'b0 || dmem.req !== 1'b0) begin
      $display("FAIL b2b_lw res=%h rd=%0d s=%b req=%b want 11223344/7/0/0",
               mem_result, mem_rd, stall, dmem.req);
      miscompares++;
    end
    step;
    idle_in;
    if (mem_valid === 1'b1) pulses++;
    vectors++;
    if (stall !== 1'b1 || dmem.req !== 1'b1 || dmem.we !== 1'b1
        || dmem.addr !== 32'h0000_3004 || dmem.wdata !== 32'hCAFE_F00D
        || dmem.be !== 4'b1111) begin
      $display("FAIL b2b_sw_bus s=%b req=%b we=%b addr=%h wd=%h be=%b want 1/1/1/00003004/cafef00d/1111",
               stall, dmem.req, dmem.we, dmem.addr, dmem.wdata, dmem.be);
      miscompares++;
    end
    dmem.ack = 1'b1;
    step;
    dmem.ack = 1'b0;
    if (mem_valid === 1'b1) pulses++;
    vectors++;
    if (mem_result !== 32'h0000_3004 || mem_Wreg !== 1'b0
        || mem_rd !== 5'd8) begin
      $display("FAIL b2b_sw_done res=%h w=%b rd=%0d want 00003004/0/8",
               mem_result, mem_Wreg, mem_rd);
      miscompares++;
    end
    step;
    if (mem_valid === 1'b1) pulses++;
    vectors++;
    if (pulses != 2) begin
      $display("FAIL b2b_pulses got=%0d want 2", pulses);
      miscompares++;
    end
  endtask

  initial begin
    dmem.rdata = '0;
    dmem.ack   = 1'b0;
    step;
    step;
    rst = 1'b0;
    test_reset;
    test_pass_through;
    test_store_byte;
    test_load("lb",  32'h0000_2001, 32'h0000_8000, 3'b000, 32'hFFFF_FF80);
    test_load("lbu", 32'h0000_2001, 32'h0000_8000, 3'b100, 32'h0000_0080);
    test_load("lh",  32'h0000_2002, 32'h8001_0000, 3'b001, 32'hFFFF_8001);
    test_load("lhu", 32'h0000_2002, 32'h8001_0000, 3'b101, 32'h0000_8001);
    test_load("lw",  32'h0000_2004, 32'hDEAD_BEEF, 3'b010, 32'hDEAD_BEEF);
    test_fault("lw_misaligned", 32'h0000_2002, 3'b010);
    test_fault("ld_func3_011",  32'h0000_2000, 3'b011);
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage of the five-stage core: consumes the registered EXE stage outputs (ALU result, rs2, rd, control bits, func3) and produces the registered MEM→WB bundle (rd, result, Wreg, Rmem). Performs RV32I loads and stores over a req/ack data-memory bus with byte-enable generation, store-data replication, load extraction and sign/zero extension. Memory operations are multi-cycle; the stage raises `stall` to freeze upstream stages until the bus acknowledges.

## Interface
- No parameters; XLEN fixed at 32.
- `clk  in  1  core clock; all state updates on rising edge`
- `rst  in  1  synchronous, active-high reset`
- `exe_valid  in  1  EXE bundle holds a live instruction`
- `exe_result  in  32  ALU result; effective address for loads/stores`
- `exe_rs2  in  32  store data`
- `exe_rd  in  5  destination register`
- `exe_Wmem / exe_Rmem / exe_Wreg  in  1 each  store / load / register-write controls`
- `exe_func3  in  3  access size/sign`
- `stall  out  1  upstream must hold EXE bundle stable`
- `mem_valid  out  1  MEM bundle valid this cycle`
- `mem_rd  out  5`, `mem_result  out  32`, `mem_Wreg  out  1`, `mem_Rmem  out  1`
- `mem_fault  out  1  misaligned or illegal-func3 access (one-cycle pulse, with mem_valid)`
- `dmem_req  out  1`, `dmem_we  out  1`, `dmem_addr  out  32  word-aligned ({addr[31:2],2'b00})`
- `dmem_wdata  out  32`, `dmem_be  out  4`
- `dmem_rdata  in  32`, `dmem_ack  in  1  single-cycle completion strobe`

## Operation
- States: IDLE, BUSY. Reset → IDLE; all outputs 0.
- IDLE, exe_valid=0: next cycle mem_valid=0, other MEM outputs hold 0.
- IDLE, exe_valid=1, Wmem=Rmem=0: pass-through, registered: mem_result=exe_result, mem_rd=exe_rd, mem_Wreg=exe_Wreg, mem_Rmem=0, mem_valid=1.
- IDLE, memory op: check legality. Load func3 ∈ {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}; store func3 ∈ {000 SB, 001 SH, 010 SW}. Halfword needs addr[0]=0; word needs addr[1:0]=00. Wmem=Rmem=1 is illegal.
- Illegal: no bus request; next cycle mem_valid=1, mem_fault=1, mem_Wreg=0, mem_result=address, mem_rd=exe_rd.
- Legal: capture address, rd, func3, Wreg, type, store data into internal registers; go BUSY.
- BUSY: dmem_req=1, dmem_addr/we/be/wdata from captured values, stable until ack. stall=1.
- Store: SB wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0]; SH wdata={2{rs2[15:0]}}, be=addr[1]?1100:0011; SW wdata=rs2, be=1111. dmem_we=1.
- Load: dmem_we=0, dmem_be=1111. Extract the byte at addr[1:0] / halfword at addr[1]; sign-extend LB/LH, zero-extend LBU/LHU, LW unchanged.
- BUSY with dmem_ack: on that edge → IDLE; mem_valid=1; load: mem_result=extended data, mem_Rmem=1, mem_Wreg=captured Wreg; store: mem_Wreg=0, mem_Rmem=0, mem_result=address.
- dmem_ack in IDLE is ignored.

## Timing
- stall = (state==BUSY), combinational from state; includes the ack cycle.
- Pass-through and fault latency: 1 cycle. Memory op: accept edge, ≥1 BUSY cycle, result valid the cycle after the ack edge. With ack in first BUSY cycle: op presented at cycle N, mem_valid at N+2.
- mem_valid=0 during every BUSY cycle (bubble to WB); mem_valid and mem_fault are one-cycle pulses per instruction.
- Upstream instruction presented during BUSY is accepted in the first IDLE cycle after the ack edge.
- rst mid-BUSY: next cycle IDLE, dmem_req=0, stall=0, outstanding op discarded; any late ack ignored.
- Back-to-back memory ops: one bus transaction at a time, no overlap.

## Test plan
- Reset: assert rst 2 cycles during BUSY → stall=0, dmem_req=0, all MEM outputs 0 next cycle.
- ALU pass-through: result=0x1234_5678, rd=5, Wreg=1 → next cycle mem_valid=1, mem_result=0x1234_5678, mem_rd=5, stall never 1.
- SB addr=0x1003, rs2=0xAABB_CCDD, ack after 3 cycles → dmem_addr=0x1000, be=1000, wdata=0xDDDD_DDDD, stall=1 for 3 cycles, mem_Wreg=0.
- LB addr=0x2001, rdata=0x0000_8000 → mem_result=0xFFFF_FF80; LBU same → 0x0000_0080; LH addr=0x2002, rdata=0x8001_0000 → 0xFFFF_8001.
- LW addr=0x2002 → no dmem_req, next cycle mem_fault=1, mem_valid=1, mem_Wreg=0; func3=011 load → same.
- Back-to-back LW then SW with 1-cycle acks → two separate transactions, second accepted the cycle after first ack edge, mem_valid pulses twice.
